// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the accumulator CPU microsequencer:
// state enum, opcodes, busC sources, ALU operations and the control word.
package cpu_ctrl_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_F_ADDR,
      S_F_MEM,
      S_DECODE,
      S_O_ADDR,
      S_O_MEM,
      S_EXEC,
      S_E_MEM,
      S_END,
      S_STEP_WAIT,
      S_HALT,
      S_FAULT
   } state_t;

   localparam logic [4:0] OP_NOP = 5'h00;
   localparam logic [4:0] OP_LDA = 5'h01;
   localparam logic [4:0] OP_STA = 5'h02;
   localparam logic [4:0] OP_ADD = 5'h03;
   localparam logic [4:0] OP_SUB = 5'h04;
   localparam logic [4:0] OP_JMP = 5'h05;
   localparam logic [4:0] OP_JZ  = 5'h06;
   localparam logic [4:0] OP_HLT = 5'h1F;

   localparam logic [1:0] BUSC_PC   = 2'd0;
   localparam logic [1:0] BUSC_OPND = 2'd1;
   localparam logic [1:0] BUSC_ACC  = 2'd2;
   localparam logic [1:0] BUSC_MEM  = 2'd3;

   localparam logic [1:0] ALU_PASS = 2'd0;
   localparam logic [1:0] ALU_ADD  = 2'd1;
   localparam logic [1:0] ALU_SUB  = 2'd2;

   typedef struct packed {
      logic       ena_ir;
      logic       sel_ir;
      logic       hmar;
      logic [1:0] busc_sel;
      logic       pc_inc;
      logic       pc_load;
      logic       mem_rd;
      logic       mem_wr;
      logic       acc_ld;
      logic [1:0] alu_op;
      logic       halted;
      logic       fault;
   } ctrl_t;

   function automatic logic [1:0] alu_sel(input logic [4:0] op);
      case (op)
         OP_ADD:  return ALU_ADD;
         OP_SUB:  return ALU_SUB;
         default: return ALU_PASS;
      endcase
   endfunction

endpackage

// File: rtl/cpu_control_sequencer_mem_wait_timer.sv
// Memory wait timer: counts cycles spent waiting for mem_ack; expired flags
// that the current wait cycle is the last one allowed.
module mem_wait_timer #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned W = $clog2(MEM_TIMEOUT + 1);

   logic [W-1:0] count_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= '0;
      end else if (en && (count_q != W'(MEM_TIMEOUT))) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign expired = (count_q == W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/cpu_control_sequencer.sv
// Microsequencer for the accumulator CPU: fetch, operand fetch, execute.
// Optional single-step mode is enabled with the SEQ_SINGLE_STEP_EN macro.
module cpu_control_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT    = 15,
   parameter bit          RESET_ON_FAULT = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic [4:0] opcode,
   input  logic       zero_flag,
   input  logic       mem_ack,
`ifdef SEQ_SINGLE_STEP_EN
   input  logic       step,
`endif
   output logic       ena_ir,
   output logic       sel_ir,
   output logic       hmar,
   output logic [1:0] busc_sel,
   output logic       pc_inc,
   output logic       pc_load,
   output logic       mem_rd,
   output logic       mem_wr,
   output logic       acc_ld,
   output logic [1:0] alu_op,
   output logic       halted,
   output logic       fault
);

   state_t     state, next_state;
   ctrl_t      ctrl_q, ctrl_d;
   logic [4:0] opc_q;
   logic       zf_q;
   logic       in_mem;
   logic       tmr_clr;
   logic       tmr_en;
   logic       tmr_expired;
   logic       step_rise;

   assign in_mem  = (state == S_F_MEM) || (state == S_O_MEM) || (state == S_E_MEM);
   assign tmr_clr = !in_mem;
   assign tmr_en  = in_mem && !mem_ack;

   mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (tmr_clr),
      .en      (tmr_en),
      .expired (tmr_expired)
   );

`ifdef SEQ_SINGLE_STEP_EN
   logic step_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         step_q <= 1'b0;
      end else begin
         step_q <= step;
      end
   end

   assign step_rise = step && !step_q;
`else
   assign step_rise = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= S_IDLE;
         ctrl_q <= '0;
         opc_q  <= '0;
         zf_q   <= 1'b0;
      end else begin
         state  <= next_state;
         ctrl_q <= ctrl_d;
         if (state == S_DECODE) begin
            opc_q <= opcode;
            zf_q  <= zero_flag;
         end
      end
   end

   // ctrl_d is the control word for the cycle after this edge, so every
   // strobe is registered; ack strobes show up in the cycle after the ack.
   always_comb begin
      next_state = state;
      ctrl_d     = '0;
      case (state)
         S_IDLE: begin
            if (run) begin
               next_state      = S_F_ADDR;
               ctrl_d.hmar     = 1'b1;
               ctrl_d.busc_sel = BUSC_PC;
            end
         end
         S_F_ADDR: begin
            next_state    = S_F_MEM;
            ctrl_d.mem_rd = 1'b1;
         end
         S_F_MEM: begin
            if (mem_ack) begin
               next_state      = S_DECODE;
               ctrl_d.ena_ir   = 1'b1;
               ctrl_d.sel_ir   = 1'b0;
               ctrl_d.busc_sel = BUSC_MEM;
               ctrl_d.pc_inc   = 1'b1;
            end else if (tmr_expired) begin
               next_state   = S_FAULT;
               ctrl_d.fault = 1'b1;
            end else begin
               ctrl_d.mem_rd = 1'b1;
            end
         end
         S_DECODE: begin
            case (opcode)
               OP_NOP: begin
                  if (run) begin
                     next_state      = S_F_ADDR;
                     ctrl_d.hmar     = 1'b1;
                     ctrl_d.busc_sel = BUSC_PC;
                  end else begin
                     next_state = S_IDLE;
                  end
               end
               OP_HLT: begin
                  next_state    = S_HALT;
                  ctrl_d.halted = 1'b1;
               end
               OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_JMP, OP_JZ: begin
                  next_state      = S_O_ADDR;
                  ctrl_d.hmar     = 1'b1;
                  ctrl_d.busc_sel = BUSC_PC;
               end
               default: begin
                  next_state   = S_FAULT;
                  ctrl_d.fault = 1'b1;
               end
            endcase
         end
         S_O_ADDR: begin
            next_state    = S_O_MEM;
            ctrl_d.mem_rd = 1'b1;
         end
         S_O_MEM: begin
            if (mem_ack) begin
               next_state      = S_EXEC;
               ctrl_d.ena_ir   = 1'b1;
               ctrl_d.sel_ir   = 1'b1;
               ctrl_d.busc_sel = BUSC_MEM;
               ctrl_d.pc_inc   = 1'b1;
            end else if (tmr_expired) begin
               next_state   = S_FAULT;
               ctrl_d.fault = 1'b1;
            end else begin
               ctrl_d.mem_rd = 1'b1;
            end
         end
         S_EXEC: begin
            case (opc_q)
               OP_JMP: begin
                  next_state     = S_END;
                  ctrl_d.pc_load = 1'b1;
               end
               OP_JZ: begin
                  next_state     = S_END;
                  ctrl_d.pc_load = zf_q;
               end
               OP_STA: begin
                  next_state      = S_E_MEM;
                  ctrl_d.hmar     = 1'b1;
                  ctrl_d.busc_sel = BUSC_OPND;
                  ctrl_d.mem_wr   = 1'b1;
               end
               default: begin
                  next_state      = S_E_MEM;
                  ctrl_d.hmar     = 1'b1;
                  ctrl_d.busc_sel = BUSC_OPND;
                  ctrl_d.mem_rd   = 1'b1;
               end
            endcase
         end
         S_E_MEM: begin
            if (mem_ack) begin
               next_state = S_END;
               if (opc_q != OP_STA) begin
                  ctrl_d.acc_ld   = 1'b1;
                  ctrl_d.busc_sel = BUSC_MEM;
                  ctrl_d.alu_op   = alu_sel(opc_q);
               end
            end else if (tmr_expired) begin
               next_state   = S_FAULT;
               ctrl_d.fault = 1'b1;
            end else if (opc_q == OP_STA) begin
               ctrl_d.mem_wr   = 1'b1;
               ctrl_d.busc_sel = BUSC_ACC;
            end else begin
               ctrl_d.mem_rd   = 1'b1;
               ctrl_d.busc_sel = BUSC_MEM;
            end
         end
         S_END: begin
            if (!run) begin
               next_state = S_IDLE;
            end else begin
`ifdef SEQ_SINGLE_STEP_EN
               next_state = S_STEP_WAIT;
`else
               next_state      = S_F_ADDR;
               ctrl_d.hmar     = 1'b1;
               ctrl_d.busc_sel = BUSC_PC;
`endif
            end
         end
         S_STEP_WAIT: begin
            if (!run) begin
               next_state = S_IDLE;
            end else if (step_rise) begin
               next_state      = S_F_ADDR;
               ctrl_d.hmar     = 1'b1;
               ctrl_d.busc_sel = BUSC_PC;
            end
         end
         S_HALT: begin
            ctrl_d.halted = 1'b1;
         end
         S_FAULT: begin
            if (RESET_ON_FAULT) begin
               next_state = S_IDLE;
            end else begin
               ctrl_d.fault = 1'b1;
            end
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   assign ena_ir   = ctrl_q.ena_ir;
   assign sel_ir   = ctrl_q.sel_ir;
   assign hmar     = ctrl_q.hmar;
   assign busc_sel = ctrl_q.busc_sel;
   assign pc_inc   = ctrl_q.pc_inc;
   assign pc_load  = ctrl_q.pc_load;
   assign mem_rd   = ctrl_q.mem_rd;
   assign mem_wr   = ctrl_q.mem_wr;
   assign acc_ld   = ctrl_q.acc_ld;
   assign alu_op   = ctrl_q.alu_op;
   assign halted   = ctrl_q.halted;
   assign fault    = ctrl_q.fault;

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Bench for cpu_control_sequencer: directed table, hand-built corner cases
// and randomized instruction streams against a per-phase trace model.
module tb_cpu_control_sequencer;

   // Observed word: {ena_ir, sel_ir, hmar, busc_sel, pc_inc, pc_load,
   //                 mem_rd, mem_wr, acc_ld, alu_op, halted, fault}
   localparam logic [13:0] E_ENA   = 14'h2000;
   localparam logic [13:0] E_SEL   = 14'h1000;
   localparam logic [13:0] E_HMAR  = 14'h0800;
   localparam logic [13:0] E_BOPND = 14'h0200;
   localparam logic [13:0] E_BACC  = 14'h0400;
   localparam logic [13:0] E_BMEM  = 14'h0600;
   localparam logic [13:0] E_PCINC = 14'h0100;
   localparam logic [13:0] E_PCLD  = 14'h0080;
   localparam logic [13:0] E_RD    = 14'h0040;
   localparam logic [13:0] E_WR    = 14'h0020;
   localparam logic [13:0] E_ACC   = 14'h0010;
   localparam logic [13:0] E_ADD   = 14'h0004;
   localparam logic [13:0] E_SUB   = 14'h0008;
   localparam logic [13:0] E_HALT  = 14'h0002;
   localparam logic [13:0] E_FAULT = 14'h0001;
   localparam logic [13:0] FACK    = E_ENA | E_BMEM | E_PCINC;
   localparam logic [13:0] OACK    = E_ENA | E_SEL | E_BMEM | E_PCINC;

   typedef struct {
      bit          run;
      logic [4:0]  op;
      bit          zf;
      bit          ack;
      logic [13:0] exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       run = 1'b0;
   logic [4:0] opcode = '0;
   logic       zero_flag = 1'b0;
   logic       mem_ack = 1'b0;
   logic       step = 1'b0;
   logic       ena_ir, sel_ir, hmar, pc_inc, pc_load, mem_rd, mem_wr, acc_ld, halted, fault;
   logic [1:0] busc_sel, alu_op;
   logic [13:0] obs;

   int   checks = 0;
   int   errors = 0;
   bit   noisy  = 1'b0;
   vec_t tr[$];

   always #5 clk = ~clk;

   cpu_control_sequencer #(.MEM_TIMEOUT(15), .RESET_ON_FAULT(1'b0)) dut (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .opcode    (opcode),
      .zero_flag (zero_flag),
      .mem_ack   (mem_ack),
`ifdef SEQ_SINGLE_STEP_EN
      .step      (step),
`endif
      .ena_ir    (ena_ir),
      .sel_ir    (sel_ir),
      .hmar      (hmar),
      .busc_sel  (busc_sel),
      .pc_inc    (pc_inc),
      .pc_load   (pc_load),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .acc_ld    (acc_ld),
      .alu_op    (alu_op),
      .halted    (halted),
      .fault     (fault)
   );

   assign obs = {ena_ir, sel_ir, hmar, busc_sel, pc_inc, pc_load,
                 mem_rd, mem_wr, acc_ld, alu_op, halted, fault};

   task automatic check(input string name, input int idx, input logic [13:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: outputs=%h expected=%h at %0t", name, idx, obs, exp, $time);
      end
   endtask

   function automatic bit nz();
      return noisy ? bit'($urandom_range(0, 1)) : 1'b0;
   endfunction

   function automatic void push(input logic [13:0] e, input bit ack, input logic [4:0] op,
                                input bit zf, input bit r);
      vec_t v;
      v.run = r; v.op = op; v.zf = zf; v.ack = ack; v.exp = e;
      tr.push_back(v);
   endfunction

   // A memory phase lasts d+1 cycles; ack is given in the last one.
   function automatic void mem_phase(input int unsigned d, input logic [13:0] first,
                                     input logic [13:0] rest, input logic [4:0] op, input bit zf);
      for (int unsigned k = 0; k <= d; k++)
         push((k == 0) ? first : rest, (k == d), op, zf, 1'b1);
   endfunction

   function automatic logic [13:0] alu_exp(input logic [4:0] op);
      if (op == 5'h03) return E_ADD;
      if (op == 5'h04) return E_SUB;
      return 14'h0;
   endfunction

   // Expected visible trace of one instruction, starting with its address cycle.
   function automatic void add_instr(input logic [4:0] op, input bit zf, input int unsigned d1,
                                     input int unsigned d2, input int unsigned d3);
      logic [4:0] po;
      bit         pz;
      push(E_HMAR, nz(), op, zf, 1'b1);
      mem_phase(d1, E_RD, E_RD, op, zf);
      push(FACK, nz(), op, zf, 1'b1);
      if (op == 5'h00) return;
      if (op == 5'h1F) begin
         for (int k = 0; k < 6; k++) push(E_HALT, nz(), op, zf, bit'($urandom_range(0, 1)));
         return;
      end
      po = noisy ? 5'($urandom) : op;
      pz = noisy ? bit'($urandom_range(0, 1)) : zf;
      push(E_HMAR, nz(), po, pz, 1'b1);
      mem_phase(d2, E_RD, E_RD, po, pz);
      push(OACK, nz(), po, pz, 1'b1);
      case (op)
         5'h05: push(E_PCLD, nz(), po, pz, 1'b1);
         5'h06: push(zf ? E_PCLD : 14'h0, nz(), po, pz, 1'b1);
         5'h02: begin
            mem_phase(d3, E_HMAR | E_BOPND | E_WR, E_BACC | E_WR, po, pz);
            push(14'h0, nz(), po, pz, 1'b1);
         end
         default: begin
            mem_phase(d3, E_HMAR | E_BOPND | E_RD, E_BMEM | E_RD, po, pz);
            push(E_ACC | E_BMEM | alu_exp(op), nz(), po, pz, 1'b1);
         end
      endcase
   endfunction

   task automatic do_reset();
      rst = 1'b0; run = 1'b1; mem_ack = 1'b0; opcode = '0; zero_flag = 1'b0;
      #1 check("reset_async", 0, 14'h0);
      for (int i = 1; i <= 3; i++) begin
         @(posedge clk); #1;
         check("reset_hold", i, 14'h0);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic run_trace(input string name);
      for (int i = 0; i < tr.size(); i++) begin
         @(posedge clk); #1;
         check(name, i, tr[i].exp);
         run = tr[i].run; opcode = tr[i].op; zero_flag = tr[i].zf; mem_ack = tr[i].ack;
      end
      tr.delete();
   endtask

   initial begin
      vec_t tbl [9];
      tbl = '{
         '{1'b1, 5'h00, 1'b0, 1'b0, E_HMAR},
         '{1'b1, 5'h00, 1'b0, 1'b1, E_RD},
         '{1'b1, 5'h00, 1'b0, 1'b0, FACK},
         '{1'b1, 5'h00, 1'b0, 1'b0, E_HMAR},
         '{1'b1, 5'h00, 1'b0, 1'b1, E_RD},
         '{1'b1, 5'h0A, 1'b0, 1'b0, FACK},
         '{1'b1, 5'h0A, 1'b0, 1'b1, E_FAULT},
         '{1'b0, 5'h00, 1'b0, 1'b0, E_FAULT},
         '{1'b1, 5'h1F, 1'b1, 1'b1, E_FAULT}
      };

      // NOP loop then illegal opcode, fault held
      do_reset();
      for (int i = 0; i < 9; i++) begin
         @(posedge clk); #1;
         check("table", i, tbl[i].exp);
         run = tbl[i].run; opcode = tbl[i].op; zero_flag = tbl[i].zf; mem_ack = tbl[i].ack;
      end
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         check("fault_hold", i, E_FAULT);
         run = ~run; mem_ack = ~mem_ack;
      end

      // LDA with 3-cycle waits, then JZ taken and not taken
      do_reset();
      add_instr(5'h01, 1'b0, 3, 3, 3);
      add_instr(5'h06, 1'b1, 0, 0, 0);
      add_instr(5'h06, 1'b0, 1, 2, 0);
      add_instr(5'h00, 1'b0, 0, 0, 0);
      run_trace("lda_jz");

      // Memory timeout during instruction fetch
      do_reset();
      push(E_HMAR, 1'b0, 5'h00, 1'b0, 1'b1);
      for (int i = 0; i < 15; i++) push(E_RD, 1'b0, 5'h00, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) push(E_FAULT, 1'b0, 5'h00, 1'b0, 1'b1);
      run_trace("timeout");

      // Halt ignores run
      do_reset();
      add_instr(5'h1F, 1'b0, 1, 0, 0);
      run_trace("halt");

      // Reset during fetch wait drops mem_rd immediately and returns to IDLE
      do_reset();
      push(E_HMAR, 1'b0, 5'h00, 1'b0, 1'b1);
      push(E_RD, 1'b0, 5'h00, 1'b0, 1'b1);
      push(E_RD, 1'b0, 5'h00, 1'b0, 1'b1);
      run_trace("pre_reset");
      #2 rst = 1'b0;
      #1 check("reset_mid_fetch", 0, 14'h0);
      @(negedge clk);
      run = 1'b0;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("idle_after_reset", i, 14'h0);
      end
      run = 1'b1;
      @(posedge clk); #1;
      check("restart", 0, E_HMAR);

      // Randomized instruction stream with ack noise outside memory phases
      do_reset();
      noisy = 1'b1;
      for (int n = 0; n < 40; n++)
         add_instr(5'($urandom_range(0, 6)), bit'($urandom_range(0, 1)),
                   $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4));
      run_trace("random");
      noisy = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
